fifo_word_packer: RTL
=====================

// Module: fifo_word_packer
// PURPOSE
//  Downstream consumer of the 8-entry byte FIFO. Pops bytes over the FIFO's push/pop/empty
//  interface and packs BYTES_PER_WORD consecutive bytes into one word. Presents each word on a
//  valid/ready output port toward the bus/DMA stage. Absorbs the FIFO's 1-cycle registered read
//  latency: data appears on fifo_out the cycle after pop && !fifo_empty.
// PARAMETERS
//  BYTES_PER_WORD  4   bytes per output word; legal values 2..8
//  TIMEOUT_CYCLES  16  idle cycles before a partial word is flushed (only with PACKER_TIMEOUT_EN)
// PORTS
//  clk         in   1         system clock, rising edge
//  rst         in   1         synchronous, active-low reset (0 = reset, sampled on posedge clk)
//  fifo_empty  in   1         FIFO empty flag
//  fifo_out    in   8         FIFO read data, valid the cycle after an accepted pop
//  fifo_pop    out  1         pop request to FIFO
//  word_data   out  8*BPW     packed word; byte k at bits [8k+7:8k]; first popped byte is byte 0
//  word_keep   out  BPW       byte-valid mask for word_data
//  word_valid  out  1         word_data/word_keep valid
//  word_ready  in   1         downstream accepts when word_valid && word_ready
//  byte_cnt    out  4         bytes currently captured in the assembly register (0..BPW)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): fifo_pop=0, word_valid=0, word_data=0, word_keep=0, byte_cnt=0,
//    in-flight flag cleared, state=FILL. A partial word is discarded. A pop issued in the reset
//    cycle is not captured.
//  - States:
//    FILL: collecting bytes.
//    HOLD: word_valid=1, waiting for word_ready. FILL->HOLD when byte_cnt reaches BPW.
//    HOLD->FILL on the handshake. At that point byte_cnt=0 and word_data/word_keep clear to 0.
//  - fifo_pop is combinational = !fifo_empty && state==FILL && (byte_cnt + inflight) < BPW.
//    inflight is a register = fifo_pop && !fifo_empty from the previous cycle.
//  - Capture: when inflight==1, fifo_out goes to lane byte_cnt, and byte_cnt increments.
//    Back-to-back pops are allowed, giving 1 byte/clk while filling.
//  - No pop is issued in HOLD. The last byte's pop is never over-issued.
//  - Output latency: the last byte is popped in cycle t, captured at t+1, and word_valid=1 from t+2.
//  - In HOLD, word_data and word_keep are stable until accepted. word_valid does not drop without
//    word_ready.
//  - Full-word word_keep = all ones.
//  - FIFO empty mid-word: no pop; the partial word is held indefinitely
//    (unless PACKER_TIMEOUT_EN is defined).
//  - word_ready while word_valid==0 is ignored.
// CONFIGURATION
//  PACKER_TIMEOUT_EN defined:
//    - An idle counter runs in FILL when byte_cnt>0 and inflight==0 and no pop is issued.
//      It clears on any pop or capture.
//    - When it reaches TIMEOUT_CYCLES: go to HOLD with the partial word. word_keep has its low
//      byte_cnt bits set; unused lanes are 0.
//  PACKER_TIMEOUT_EN undefined: no counter, partial words are never emitted, and word_keep is
//    all ones whenever word_valid=1.
// STRUCTURE
//  - Shared package packer_pkg:
//    - state typedef {FILL, HOLD}
//    - BYTE_W=8
//    - CNT_W=4
//  - One sub-module: packer_idle_timer. It is instantiated only under PACKER_TIMEOUT_EN.
//    Inputs: clk, rst, run, clear. Output: expired.
// TESTING (BPW=4, TIMEOUT_CYCLES=16, bench drives a real 8-deep FIFO model)
//  1. Push 0x11,0x22,0x33,0x44, word_ready=1 -> one word 0x44332211, keep=4'hF.
//     word_valid is high for exactly 1 cycle; 4 pops total.
//  2. Push 8 bytes 0x01..0x08, word_ready=0 for 10 cycles -> word_valid held with 0x04030201,
//     and fifo_pop stays 0 in HOLD. Release ready -> 0x08070605 follows.
//  3. Back-to-back: FIFO pre-filled with 8 bytes -> fifo_pop high 4 consecutive cycles.
//     word_valid rises 2 cycles after the 4th pop.
//  4. rst low for 1 cycle after 2 bytes captured -> byte_cnt=0, word_valid=0.
//     The next 4 pushes 0xA0..0xA3 yield 0xA3A2A1A0.
//  5. PACKER_TIMEOUT_EN: push 0x5A,0x6B, then stop -> 16 idle cycles later word_valid=1,
//     word_data=0x00006B5A, keep=4'h3.
//  6. Undefined macro, same stimulus as 5 -> word_valid stays 0 for 100 cycles and byte_cnt=2.

Source files
------------

// File: rtl/packer_pkg.sv
// Shared types and widths for the FIFO word packer.
package packer_pkg;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;
endpackage

// File: rtl/packer_idle_timer.sv
// Idle counter for partial-word flushing; used only when PACKER_TIMEOUT_EN is defined.
module packer_idle_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) count_d = '0;
    else if (run) count_d = count_q + 1'b1;
  end

  // Fires during the TIMEOUT_CYCLES-th consecutive idle cycle.
  assign expired = run && (count_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end
endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from a registered-read FIFO and packs BYTES_PER_WORD of them into a valid/ready word.
// Optional partial-word flush after an idle timeout when PACKER_TIMEOUT_EN is defined.
module fifo_word_packer
  import packer_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               fifo_empty,
  input  logic [BYTE_W-1:0]                  fifo_out,
  output logic                               fifo_pop,
  output logic [BYTE_W*BYTES_PER_WORD-1:0]   word_data,
  output logic [BYTES_PER_WORD-1:0]          word_keep,
  output logic                               word_valid,
  input  logic                               word_ready,
  output logic [CNT_W-1:0]                   byte_cnt
);
  localparam int WORD_W = BYTE_W * BYTES_PER_WORD;

  if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8) begin : g_bad_bpw
    $error("BYTES_PER_WORD must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic                inflight_q, inflight_d;
  logic [WORD_W-1:0]   word_data_q, word_data_d;
  logic [BYTES_PER_WORD-1:0] word_keep_q, word_keep_d;
  logic                timeout_hit;
  logic [CNT_W:0]      pending;

  // Count the byte still in the FIFO read register so the last pop is never over-issued.
  assign pending  = {1'b0, byte_cnt_q} + (CNT_W + 1)'(inflight_q);
  assign fifo_pop = !fifo_empty && (state_q == FILL) &&
                    (pending < (CNT_W + 1)'(BYTES_PER_WORD));

`ifdef PACKER_TIMEOUT_EN
  logic idle_run, idle_clear, idle_expired;

  assign idle_run   = (state_q == FILL) && (byte_cnt_q != '0) && !inflight_q && !fifo_pop;
  assign idle_clear = fifo_pop || inflight_q || (state_q != FILL);

  packer_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (idle_run),
    .clear  (idle_clear),
    .expired(idle_expired)
  );

  assign timeout_hit = idle_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_data_d = word_data_q;
    word_keep_d = word_keep_q;
    inflight_d  = fifo_pop;
    case (state_q)
      FILL: begin
        if (inflight_q) begin
          for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (byte_cnt_q == CNT_W'(k)) begin
              word_data_d[k*BYTE_W +: BYTE_W] = fifo_out;
              word_keep_d[k]                  = 1'b1;
            end
          end
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1)) state_d = HOLD;
        end else if (timeout_hit) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (word_ready) begin
          state_d     = FILL;
          byte_cnt_d  = '0;
          word_data_d = '0;
          word_keep_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL;
      byte_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      word_data_q <= '0;
      word_keep_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      inflight_q  <= inflight_d;
      word_data_q <= word_data_d;
      word_keep_q <= word_keep_d;
    end
  end

  assign word_valid = (state_q == HOLD);
  assign word_data  = word_data_q;
  assign word_keep  = word_keep_q;
  assign byte_cnt   = byte_cnt_q;
endmodule
